// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide issue logic
//   state_t     : divide issue FSM states
//   DIV0_LO     : LO value written for a bypassed divide by zero
//   DIV_LATENCY : iterations the divider needs after it captures operands
package mdu_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
    localparam int DIV_LATENCY = 32;
endpackage

// File: rtl/hilo_reg.sv
// hilo_reg: architectural HI/LO register pair
//   clk, reset      : clock, synchronous active-high reset (clears both)
//   hi_we / lo_we   : independent write enables
//   hi_d / lo_d     : write data
//   hi / lo         : registered contents
module hilo_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hi_d,
    input  logic [31:0] lo_d,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_d;
            if (lo_we) lo <= lo_d;
        end
    end
endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage issue controller for the iterative signed divider
//   clk, reset                   : clock, synchronous active-high reset
//   ex_div_valid, ex_rs, ex_rt   : DIV in EX and its operands
//   ex_mthi, ex_mtlo, ex_wdata   : move-to-HI/LO and data
//   ex_flush, pipe_stall_in      : kill EX instruction / external stall
//   div_q, div_r, div_busy, div_finish : divider results and status
//   div_start, div_dividend, div_divisor, div_cpu_stall : divider controls
//   mdu_stall                    : pipeline hold while a DIV is in flight
//   hi, lo                       : architectural HI/LO
//   div0                         : one-cycle divide-by-zero pulse
// Optional feature macro: DIV_ZERO_BYPASS_EN (zero divisor resolved locally
// in one cycle instead of being sent to the divider).
module div_issue_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_div_valid,
    input  logic [31:0] ex_rs,
    input  logic [31:0] ex_rt,
    input  logic        ex_mthi,
    input  logic        ex_mtlo,
    input  logic [31:0] ex_wdata,
    input  logic        ex_flush,
    input  logic        pipe_stall_in,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_busy,
    input  logic        div_finish,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic        div_cpu_stall,
    output logic        mdu_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div0
);
    state_t state, state_nx;
    logic hi_we, lo_we, issue, mt_ok, zero_div;
    logic [31:0] hi_d, lo_d;
    logic unused_busy;

    assign div_dividend  = ex_rs;
    assign div_divisor   = ex_rt;
    assign div_cpu_stall = pipe_stall_in;
    assign unused_busy   = div_busy;
    assign issue = state == IDLE && ex_div_valid && !pipe_stall_in && !ex_flush;
    // A DIV in EX blocks moves even when it cannot issue this cycle.
    assign mt_ok = !ex_div_valid && !pipe_stall_in && !ex_flush;

`ifdef DIV_ZERO_BYPASS_EN
    logic div0_q;
    assign zero_div = ex_rt == 32'd0;
    assign div0 = div0_q;
    always_ff @(posedge clk) begin
        if (reset) div0_q <= 1'b0;
        else       div0_q <= issue && zero_div;
    end
`else
    assign zero_div = 1'b0;
    assign div0 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        div_start = 1'b0;
        mdu_stall = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        hi_d      = ex_wdata;
        lo_d      = ex_wdata;
        case (state)
            IDLE: begin
                mdu_stall = ex_div_valid && !ex_flush;
                div_start = issue && !zero_div;
                state_nx  = issue ? (zero_div ? DONE : WAIT) : IDLE;
                hi_we     = issue ? zero_div : mt_ok && ex_mthi;
                lo_we     = issue ? zero_div : mt_ok && ex_mtlo;
                hi_d      = issue ? ex_rs : ex_wdata;
                lo_d      = issue ? DIV0_LO : ex_wdata;
            end
            WAIT: begin
                // A flush kills the DIV before its result can commit.
                mdu_stall = 1'b1;
                state_nx  = ex_flush ? IDLE : div_finish ? DONE : WAIT;
                hi_we     = !ex_flush && div_finish;
                lo_we     = !ex_flush && div_finish;
                hi_d      = div_r;
                lo_d      = div_q;
            end
            DONE: state_nx = (ex_flush || !pipe_stall_in) ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    hilo_reg u_hilo (
        .clk   (clk),
        .reset (reset),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .hi_d  (hi_d),
        .lo_d  (lo_d),
        .hi    (hi),
        .lo    (lo)
    );
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: scoreboard bench for div_issue_ctrl with a divider stub
module tb_div_issue_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_div_valid = 1'b0, ex_mthi = 1'b0, ex_mtlo = 1'b0;
    logic        ex_flush = 1'b0, pipe_stall_in = 1'b0;
    logic [31:0] ex_rs = '0, ex_rt = '0, ex_wdata = '0;
    logic [31:0] div_q, div_r;
    logic        div_busy, div_finish;
    logic        div_start, div_cpu_stall, mdu_stall, div0;
    logic [31:0] div_dividend, div_divisor, hi, lo;

    int n_chk = 0, n_pass = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_hi = '0, exp_lo = '0;

    always #5 clk = ~clk;

    div_issue_ctrl dut (
        .clk(clk), .reset(reset), .ex_div_valid(ex_div_valid), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_mthi(ex_mthi), .ex_mtlo(ex_mtlo), .ex_wdata(ex_wdata),
        .ex_flush(ex_flush), .pipe_stall_in(pipe_stall_in), .div_q(div_q),
        .div_r(div_r), .div_busy(div_busy), .div_finish(div_finish),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_cpu_stall(div_cpu_stall), .mdu_stall(mdu_stall), .hi(hi), .lo(lo),
        .div0(div0)
    );

    // Divider stub: captures on start, iterates once per unstalled cycle,
    // raises finish once all iterations are done; a new start restarts it.
    logic [31:0] a_q, b_q;
    int cnt;
    logic busy;
    assign div_busy   = busy;
    assign div_finish = busy && cnt == DIV_LATENCY;
    assign div_q = (b_q == 0) ? 32'hFFFF_FFFF : 32'($signed(a_q) / $signed(b_q));
    assign div_r = (b_q == 0) ? a_q : 32'($signed(a_q) % $signed(b_q));
    always @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0; cnt <= 0; a_q <= '0; b_q <= 32'd1;
        end else if (div_start) begin
            busy <= 1'b1; cnt <= 0; a_q <= div_dividend; b_q <= div_divisor;
        end else if (busy) begin
            if (div_finish) busy <= 1'b0;
            else if (!div_cpu_stall) cnt <= cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Runs one DIV from a negedge; returns at the negedge after it retires or is flushed.
    task automatic run_div(input logic [31:0] rs, input logic [31:0] rt,
                           input int stall_from, input int stall_n, input int flush_at,
                           input int exp_ret, input int exp_starts,
                           input logic [31:0] e_lo, input logic [31:0] e_hi, input logic e_div0);
        int starts = 0;
        logic done = 1'b0;
        logic [63:0] e;
        ex_div_valid = 1'b1; ex_rs = rs; ex_rt = rt;
        if (flush_at < 0) sb.push_back({e_lo, e_hi});
        for (int c = 0; c < 100 && !done; c++) begin
            pipe_stall_in = c >= stall_from && c < stall_from + stall_n;
            ex_flush = c == flush_at;
            #1;
            starts += int'(div_start);
            if (c == flush_at) begin
                check("flush_cycle_stall", 32'(mdu_stall), 32'd1);
                done = 1'b1;
            end else if (!mdu_stall) begin
                check("retire_cycle", 32'(c), 32'(exp_ret));
                check("div0_at_retire", 32'(div0), 32'(e_div0));
                if (sb.size() == 0) check("sb_empty", 32'd0, 32'd1);
                else begin
                    e = sb.pop_front();
                    exp_lo = e[63:32]; exp_hi = e[31:0];
                    check("lo", lo, exp_lo);
                    check("hi", hi, exp_hi);
                end
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) check("div_timeout", 32'd0, 32'd1);
        check("start_pulses", 32'(starts), 32'(exp_starts));
        ex_div_valid = 1'b0; ex_flush = 1'b0; pipe_stall_in = 1'b0;
        #1;
        check("div0_after", 32'(div0), 32'd0);
        @(negedge clk);
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] d, input logic st);
        ex_mthi = h; ex_mtlo = l; ex_wdata = d; pipe_stall_in = st;
        if (!st && h) exp_hi = d;
        if (!st && l) exp_lo = d;
        @(negedge clk);
        ex_mthi = 1'b0; ex_mtlo = 1'b0; pipe_stall_in = 1'b0;
        #1;
        check("mt_hi", hi, exp_hi);
        check("mt_lo", lo, exp_lo);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_div0", 32'(div0), 32'd0);
        check("rst_start", 32'(div_start), 32'd0);
        check("rst_stall", 32'(mdu_stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        mt(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        mt(1'b0, 1'b1, 32'h1234_5678, 1'b0);
        mt(1'b1, 1'b0, 32'hCAFE_F00D, 1'b1);
        mt(1'b1, 1'b1, 32'hA5A5_5A5A, 1'b0);

        run_div(32'd100, 32'd7, 99, 0, -1, 34, 1, 32'd14, 32'd2, 1'b0);
        run_div(-32'sd100, 32'd7, 99, 0, -1, 34, 1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run_div(32'd7, -32'sd2, 99, 0, -1, 34, 1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_div(32'd100, 32'd7, 5, 5, -1, 39, 1, 32'd14, 32'd2, 1'b0);
        run_div(32'd100, 32'd7, 0, 2, -1, 36, 1, 32'd14, 32'd2, 1'b0);

        exp_lo = 32'hDEAD_0001; exp_hi = 32'hDEAD_0002;
        mt(1'b1, 1'b1, 32'hDEAD_0003, 1'b0);
        run_div(32'd50, 32'd3, 99, 0, 10, 0, 1, 32'd0, 32'd0, 1'b0);
        check("flush_hi", hi, exp_hi);
        check("flush_lo", lo, exp_lo);
        check("flush_stall_after", 32'(mdu_stall), 32'd0);
        run_div(32'd9, 32'd4, 99, 0, -1, 34, 1, 32'd2, 32'd1, 1'b0);

`ifdef DIV_ZERO_BYPASS_EN
        run_div(32'd55, 32'd0, 99, 0, -1, 1, 0, 32'hFFFF_FFFF, 32'd55, 1'b1);
`endif

        ex_div_valid = 1'b1; ex_rs = 32'd20; ex_rt = 32'd3;
        repeat (5) @(negedge clk);
        ex_div_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_stall", 32'(mdu_stall), 32'd0);
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        run_div(32'd9, 32'd4, 99, 0, -1, 34, 1, 32'd2, 32'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Execute-stage issue controller for the iterative signed divider (start/busy/finish protocol). Drives the divider's start and operands, holds the pipeline while a DIV is in flight, and writes quotient/remainder into the architectural LO/HI pair. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ex_div_valid  in  1  signed DIV instruction present in EX
- ex_rs  in  32  dividend (forwarded rs)
- ex_rt  in  32  divisor (forwarded rt)
- ex_mthi / ex_mtlo  in  1  move-to-HI / move-to-LO in EX
- ex_wdata  in  32  data for MTHI/MTLO
- ex_flush  in  1  kill the EX instruction (exception/branch recovery)
- pipe_stall_in  in  1  stall from other pipeline sources
- div_q / div_r  in  32  divider quotient / remainder
- div_busy, div_finish  in  1  divider status
- div_start  out  1  divider start pulse (combinational)
- div_dividend / div_divisor  out  32  operands, wired from ex_rs / ex_rt
- div_cpu_stall  out  1  freezes divider iteration; equals pipe_stall_in
- mdu_stall  out  1  pipeline hold request
- hi / lo  out  32  architectural HI/LO (registered)
- div0  out  1  divide-by-zero pulse (configuration-dependent)

## Operation
- States: IDLE, WAIT, DONE. Reset: state IDLE, hi=0, lo=0, div0=0; div_start=0 and mdu_stall=0 combinationally in IDLE with no valid.
- IDLE: div_start = ex_div_valid & !pipe_stall_in & !ex_flush. On start -> WAIT. mdu_stall = ex_div_valid & !ex_flush.
- WAIT: mdu_stall=1, div_start=0. On div_finish: lo<=div_q, hi<=div_r, -> DONE. On ex_flush: -> IDLE, hi/lo unchanged (divider left running; next start overrides it).
- DONE: mdu_stall=0 so the DIV retires. Stay while pipe_stall_in=1; else -> IDLE. ex_flush -> IDLE (result already committed; instruction was the one that completed).
- div_finish seen in IDLE or DONE is ignored.
- MTHI/MTLO: hi/lo <= ex_wdata at the edge where ex_mthi/ex_mtlo=1, state IDLE, !pipe_stall_in, !ex_flush. Both asserted writes both.
- ex_div_valid together with ex_mthi/ex_mtlo: DIV takes priority, move ignored (decoder never produces this).
- Reset mid-operation: immediate return to IDLE, hi/lo=0; divider shares the same reset.

## Timing
- Cycle 0: IDLE, valid, start=1, stall=1. Divider captures at end of cycle 0.
- Cycles 1..32: WAIT (stall-free); divider iterates once per non-stalled cycle.
- Cycle 33: div_finish=1; hi/lo written at its end.
- Cycle 34: DONE, mdu_stall=0, new hi/lo visible; DIV leaves EX at end of cycle 34.
- Total 34 stall cycles; each pipe_stall_in cycle during WAIT adds exactly one.
- MTHI/MTLO: value visible on hi/lo the cycle after the write edge.

## Configuration
- DIV_ZERO_BYPASS_EN defined: divisor==0 in IDLE does not assert div_start; state -> DONE at the edge, lo<=32'hFFFF_FFFF, hi<=ex_rs, div0=1 for that one DONE cycle. Stall: 1 cycle.
- Undefined: zero divisor issued to divider like any other; hi/lo take divider output unchanged; div0 tied 0.

## Structure
- Package mdu_pkg: state enum (IDLE/WAIT/DONE), DIV0_LO constant 32'hFFFF_FFFF, DIV_LATENCY=32.
- One sub-module, hilo_reg: HI/LO register pair with sync reset and independent write enables; FSM stays in div_issue_ctrl.

## Test plan
- 100 / 7 -> start pulse in cycle 0, mdu_stall high cycles 0..33, cycle 34 lo=14, hi=2.
- -100 / 7 -> lo=32'hFFFF_FFF2, hi=32'hFFFF_FFFE; 7 / -2 -> lo=32'hFFFF_FFFD, hi=1.
- 100 / 7 with pipe_stall_in high 5 cycles during WAIT -> results in cycle 39; no start while stalled in IDLE.
- ex_flush in cycle 10 of a DIV -> IDLE next cycle, mdu_stall low, hi/lo keep prior values; following DIV 9/4 completes with lo=2, hi=1.
- MTHI 32'hDEADBEEF, MTLO 32'h12345678, then MTHI under pipe_stall_in -> only unstalled writes take effect.
- With DIV_ZERO_BYPASS_EN: 55 / 0 -> no div_start, one stall cycle, lo=32'hFFFF_FFFF, hi=55, div0 one-cycle pulse.
